// File: rtl/lsu_addr_sequencer.sv
// lsu_addr_sequencer: walks the exec mask lowest thread first, issuing one memory/LDS
// request per active thread and gathering load responses. Optional build: LSU_SEQ_COALESCE_EN.
module lsu_addr_sequencer (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_start,
  input  logic [2047:0] in_ld_st_addr,
  input  logic [2047:0] in_store_data,
  input  logic [63:0]   in_exec,
  input  logic          in_is_store,
  input  logic          in_gm_or_lds,
  input  logic          in_mem_ack,
  input  logic          in_mem_rsp_valid,
  input  logic [5:0]    in_mem_rsp_tag,
  input  logic [31:0]   in_mem_rsp_data,
  output logic          out_busy,
  output logic          out_mem_req,
  output logic          out_mem_wr_en,
  output logic [31:0]   out_mem_addr,
  output logic [31:0]   out_mem_wr_data,
  output logic [5:0]    out_mem_tag,
  output logic          out_gm_or_lds,
  output logic [2047:0] out_load_data,
  output logic          out_done
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_WAIT_RSP = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [2047:0] addr_q, addr_d;
  logic [2047:0] wdata_q, wdata_d;
  logic [63:0]   mask_q, mask_d;
  logic          is_store_q, is_store_d;
  logic          gm_or_lds_q, gm_or_lds_d;
  logic [5:0]    cur_t_q, cur_t_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wr_data_q, mem_wr_data_d;
  logic          mem_wr_en_q, mem_wr_en_d;
  logic [2047:0] load_data_q, load_data_d;
  logic          done_q, done_d;
`ifdef LSU_SEQ_COALESCE_EN
  logic          last_valid_q, last_valid_d;
  logic [31:0]   last_addr_q, last_addr_d;
  logic [31:0]   last_data_q, last_data_d;
`endif

  logic          advance;
  logic [63:0]   next_mask;
  logic [2047:0] src_addr;
  logic [2047:0] src_wdata;
  logic          src_store;
  logic [5:0]    next_t;
  logic [10:0]   next_base;
  logic [10:0]   cur_base;

  assign cur_base = {cur_t_q, 5'd0};

  function automatic logic [5:0] lowest_set(input logic [63:0] m);
    logic [5:0] idx;
    idx = '0;
    for (int i = 63; i >= 0; i--) begin
      if (m[i]) idx = i[5:0];
    end
    return idx;
  endfunction

  // Handshake: out_mem_req with addr/tag/data stays stable until a rising edge sees
  // out_mem_req=1 and in_mem_ack=1; responses only count in WAIT_RSP with a matching tag.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    mask_d        = mask_q;
    is_store_d    = is_store_q;
    gm_or_lds_d   = gm_or_lds_q;
    cur_t_d       = cur_t_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_wr_en_d   = mem_wr_en_q;
    load_data_d   = load_data_q;
    done_d        = 1'b0;
`ifdef LSU_SEQ_COALESCE_EN
    last_valid_d  = last_valid_q;
    last_addr_d   = last_addr_q;
    last_data_d   = last_data_q;
`endif
    advance   = 1'b0;
    next_mask = mask_q;
    src_addr  = addr_q;
    src_wdata = wdata_q;
    src_store = is_store_q;
    next_t    = '0;
    next_base = '0;

    case (state_q)
      ST_IDLE: begin
        if (in_start) begin
          addr_d      = in_ld_st_addr;
          wdata_d     = in_store_data;
          is_store_d  = in_is_store;
          gm_or_lds_d = in_gm_or_lds;
          load_data_d = '0;
          src_addr    = in_ld_st_addr;
          src_wdata   = in_store_data;
          src_store   = in_is_store;
          next_mask   = in_exec;
          advance     = 1'b1;
`ifdef LSU_SEQ_COALESCE_EN
          last_valid_d = 1'b0;
`endif
        end
      end
      ST_ISSUE: begin
        if (mem_req_q && in_mem_ack) begin
          if (is_store_q) begin
            next_mask[cur_t_q] = 1'b0;
            advance            = 1'b1;
          end else begin
            mem_req_d = 1'b0;
            state_d   = ST_WAIT_RSP;
          end
        end
`ifdef LSU_SEQ_COALESCE_EN
        // No request outstanding here means the thread reuses the previous load result.
        else if (!mem_req_q) begin
          load_data_d[cur_base +: 32] = last_data_q;
          next_mask[cur_t_q]          = 1'b0;
          advance                     = 1'b1;
        end
`endif
      end
      ST_WAIT_RSP: begin
        if (in_mem_rsp_valid && (in_mem_rsp_tag == cur_t_q)) begin
          load_data_d[cur_base +: 32] = in_mem_rsp_data;
          next_mask[cur_t_q]          = 1'b0;
          advance                     = 1'b1;
`ifdef LSU_SEQ_COALESCE_EN
          last_valid_d = 1'b1;
          last_addr_d  = addr_q[cur_base +: 32];
          last_data_d  = in_mem_rsp_data;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (advance) begin
      mask_d = next_mask;
      if (next_mask == '0) begin
        state_d   = ST_DONE;
        mem_req_d = 1'b0;
        done_d    = 1'b1;
      end else begin
        next_t        = lowest_set(next_mask);
        next_base     = {next_t, 5'd0};
        state_d       = ST_ISSUE;
        cur_t_d       = next_t;
        mem_addr_d    = src_addr[next_base +: 32];
        mem_wr_data_d = src_wdata[next_base +: 32];
        mem_wr_en_d   = src_store;
        mem_req_d     = 1'b1;
`ifdef LSU_SEQ_COALESCE_EN
        if (!src_store && last_valid_d && (last_addr_d == mem_addr_d)) mem_req_d = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      mask_q        <= '0;
      is_store_q    <= 1'b0;
      gm_or_lds_q   <= 1'b0;
      cur_t_q       <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_wr_en_q   <= 1'b0;
      load_data_q   <= '0;
      done_q        <= 1'b0;
`ifdef LSU_SEQ_COALESCE_EN
      last_valid_q  <= 1'b0;
      last_addr_q   <= '0;
      last_data_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      mask_q        <= mask_d;
      is_store_q    <= is_store_d;
      gm_or_lds_q   <= gm_or_lds_d;
      cur_t_q       <= cur_t_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_wr_en_q   <= mem_wr_en_d;
      load_data_q   <= load_data_d;
      done_q        <= done_d;
`ifdef LSU_SEQ_COALESCE_EN
      last_valid_q  <= last_valid_d;
      last_addr_q   <= last_addr_d;
      last_data_q   <= last_data_d;
`endif
    end
  end

  assign out_busy        = (state_q != ST_IDLE);
  assign out_mem_req     = mem_req_q;
  assign out_mem_wr_en   = mem_wr_en_q;
  assign out_mem_addr    = mem_addr_q;
  assign out_mem_wr_data = mem_wr_data_q;
  assign out_mem_tag     = cur_t_q;
  assign out_gm_or_lds   = gm_or_lds_q;
  assign out_load_data   = load_data_q;
  assign out_done        = done_q;

endmodule

// File: tb/tb_lsu_addr_sequencer.sv
// Bench for lsu_addr_sequencer: directed scenarios plus randomized operations checked
// against a per-operation request list and gathered-data model.
module tb_lsu_addr_sequencer;

`ifdef LSU_SEQ_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_start;
  logic [2047:0] in_ld_st_addr;
  logic [2047:0] in_store_data;
  logic [63:0]   in_exec;
  logic          in_is_store;
  logic          in_gm_or_lds;
  logic          in_mem_ack;
  logic          in_mem_rsp_valid;
  logic [5:0]    in_mem_rsp_tag;
  logic [31:0]   in_mem_rsp_data;
  logic          out_busy;
  logic          out_mem_req;
  logic          out_mem_wr_en;
  logic [31:0]   out_mem_addr;
  logic [31:0]   out_mem_wr_data;
  logic [5:0]    out_mem_tag;
  logic          out_gm_or_lds;
  logic [2047:0] out_load_data;
  logic          out_done;

  lsu_addr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_start(in_start), .in_ld_st_addr(in_ld_st_addr),
    .in_store_data(in_store_data), .in_exec(in_exec), .in_is_store(in_is_store),
    .in_gm_or_lds(in_gm_or_lds), .in_mem_ack(in_mem_ack), .in_mem_rsp_valid(in_mem_rsp_valid),
    .in_mem_rsp_tag(in_mem_rsp_tag), .in_mem_rsp_data(in_mem_rsp_data), .out_busy(out_busy),
    .out_mem_req(out_mem_req), .out_mem_wr_en(out_mem_wr_en), .out_mem_addr(out_mem_addr),
    .out_mem_wr_data(out_mem_wr_data), .out_mem_tag(out_mem_tag), .out_gm_or_lds(out_gm_or_lds),
    .out_load_data(out_load_data), .out_done(out_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [71:0]   exp_q[$];        // {tag, addr, wr_data, wr_en, gm_or_lds}
  logic [2047:0] exp_load;
  logic [2047:0] addr_v;
  logic [2047:0] sdata_v;
  bit            op_active = 1'b0;
  int            ack_tag_log[$];
  int            ack_addr_log[$];
  int            ack_cyc_log[$];
  int            done_cnt;
  int            done_cyc;
  int            start_cyc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [2047:0] act, input logic [2047:0] exp);
    n_checks++;
    if (act !== exp) begin
      int lane;
      lane = 0;
      for (int l = 63; l >= 0; l--) if (act[l*32 +: 32] !== exp[l*32 +: 32]) lane = l;
      n_fail++;
      $display("FAIL %s: lane %0d got 0x%08h expected 0x%08h (cycle %0d)", nm, lane,
               act[lane*32 +: 32], exp[lane*32 +: 32], cyc);
    end
  endtask

  function automatic logic [31:0] rsp_val(input int mode, input logic [5:0] tag, input logic [31:0] a);
    if (mode == 1) return 32'hA0 + {26'd0, tag};
    return (a ^ 32'hDEAD_BEEF) + 32'h0001_3579;
  endfunction

  // Reference: one request per active thread in ascending order; loads may reuse the
  // previous completed load when coalescing is built in and the address repeats.
  task automatic build_model(input logic [63:0] exec, input logic st, input logic gl, input int mode);
    logic        have_last;
    logic [31:0] last_a, last_d, a, d;
    exp_q.delete();
    exp_load  = '0;
    have_last = 1'b0;
    last_a    = '0;
    last_d    = '0;
    for (int i = 0; i < 64; i++) begin
      if (exec[i]) begin
        a = addr_v[i*32 +: 32];
        if (!st && COAL && have_last && (a == last_a)) begin
          d = last_d;
        end else begin
          exp_q.push_back({i[5:0], a, sdata_v[i*32 +: 32], st, gl});
          d = rsp_val(mode, i[5:0], a);
        end
        if (!st) begin
          exp_load[i*32 +: 32] = d;
          have_last = 1'b1;
          last_a    = a;
          last_d    = d;
        end
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [71:0] e;
    if (rst_n) begin
      if (!op_active || exp_q.size() == 0) begin
        chk("req_unexpected", 64'(out_mem_req), 64'd0);
      end else if (out_mem_req) begin
        e = exp_q[0];
        chk("req_tag", 64'(out_mem_tag), 64'(e[71:66]));
        chk("req_addr", 64'(out_mem_addr), 64'(e[65:34]));
        chk("req_wr_data", 64'(out_mem_wr_data), 64'(e[33:2]));
        chk("req_wr_en", 64'(out_mem_wr_en), 64'(e[1]));
        chk("req_gm_or_lds", 64'(out_gm_or_lds), 64'(e[0]));
        chk("req_busy", 64'(out_busy), 64'd1);
        if (in_mem_ack) begin
          ack_tag_log.push_back(int'(out_mem_tag));
          ack_addr_log.push_back(int'(out_mem_addr));
          ack_cyc_log.push_back(cyc);
          void'(exp_q.pop_front());
        end
      end
      if (!op_active) begin
        chk("done_unexpected", 64'(out_done), 64'd0);
      end else if (out_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_reqs_left", 64'(exp_q.size()), 64'd0);
        chk_vec("load_data", out_load_data, exp_load);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_op(input logic [63:0] exec, input logic st, input logic gl, input int mode,
                        input int ack_min, input int ack_max, input int rsp_min, input int rsp_max,
                        input bit stray, input bit restart, input int abort_ack);
    int          ack_cnt, n, rsp_at, acks_given;
    bit          pend, done_seen, restarted, aborted;
    logic [5:0]  pend_tag;
    logic [31:0] pend_addr;
    build_model(exec, st, gl, mode);
    ack_tag_log.delete();
    ack_addr_log.delete();
    ack_cyc_log.delete();
    done_cnt      = 0;
    done_cyc      = -1;
    in_ld_st_addr = addr_v;
    in_store_data = sdata_v;
    in_exec       = exec;
    in_is_store   = st;
    in_gm_or_lds  = gl;
    op_active     = 1'b1;
    in_start      = 1'b1;
    start_cyc     = cyc;
    @(posedge clk); #1;
    in_start   = 1'b0;
    ack_cnt    = $urandom_range(ack_max, ack_min);
    pend       = 1'b0;
    done_seen  = 1'b0;
    restarted  = 1'b0;
    aborted    = 1'b0;
    n          = 0;
    acks_given = 0;
    rsp_at     = 0;
    pend_tag   = '0;
    pend_addr  = '0;
    while (!done_seen && !aborted && n < 4000) begin
      in_mem_ack       = 1'b0;
      in_mem_rsp_valid = 1'b0;
      in_mem_rsp_tag   = 6'($urandom);
      in_mem_rsp_data  = $urandom;
      in_start         = 1'b0;
      if (out_done) begin
        done_seen = 1'b1;
      end else if (abort_ack != 0 && acks_given >= abort_ack && pend && !out_mem_req) begin
        chk("abort_lane0_before_rst", 64'(out_load_data[31:0]), 64'(exp_load[31:0]));
        rst_n   = 1'b0;
        aborted = 1'b1;
      end else begin
        if (out_mem_req) begin
          if (ack_cnt == 0) begin
            in_mem_ack = 1'b1;
            acks_given++;
            ack_cnt = $urandom_range(ack_max, ack_min);
            if (!st) begin
              pend      = 1'b1;
              pend_tag  = out_mem_tag;
              pend_addr = out_mem_addr;
              rsp_at    = cyc + $urandom_range(rsp_max, rsp_min);
            end
          end else begin
            ack_cnt--;
          end
          if (stray && $urandom_range(0, 1) == 1) in_mem_rsp_valid = 1'b1;
        end else if (pend) begin
          if (cyc == rsp_at) begin
            in_mem_rsp_valid = 1'b1;
            in_mem_rsp_tag   = pend_tag;
            in_mem_rsp_data  = rsp_val(mode, pend_tag, pend_addr);
            pend             = 1'b0;
          end else if (stray) begin
            in_mem_rsp_valid = 1'b1;
            in_mem_rsp_tag   = pend_tag ^ 6'($urandom_range(1, 63));
          end
        end
        if (restart && !restarted) begin
          in_start      = 1'b1;
          in_exec       = ~exec;
          in_is_store   = ~st;
          in_gm_or_lds  = ~gl;
          in_ld_st_addr = ~addr_v;
          restarted     = 1'b1;
        end
      end
      if (!done_seen && !aborted) begin
        @(posedge clk); #1;
        n++;
      end
    end
    in_mem_ack       = 1'b0;
    in_mem_rsp_valid = 1'b0;
    in_start         = 1'b0;
    if (aborted) begin
      @(posedge clk); #1;
      chk("rst_busy", 64'(out_busy), 64'd0);
      chk("rst_req", 64'(out_mem_req), 64'd0);
      chk("rst_done", 64'(out_done), 64'd0);
      chk_vec("rst_load_data", out_load_data, '0);
      rst_n     = 1'b1;
      op_active = 1'b0;
      exp_q.delete();
      repeat (4) begin
        @(posedge clk); #1;
        chk("rst_no_done_later", 64'(out_done), 64'd0);
      end
    end else begin
      chk("op_completed", 64'(done_seen), 64'd1);
      if (!done_seen) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      @(posedge clk); #1;
      chk("busy_after_done", 64'(out_busy), 64'd0);
      op_active = 1'b0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] exec_r;
    rst_n = 1'b0; in_start = 1'b0; in_ld_st_addr = '0; in_store_data = '0; in_exec = '0;
    in_is_store = 1'b0; in_gm_or_lds = 1'b0; in_mem_ack = 1'b0; in_mem_rsp_valid = 1'b0;
    in_mem_rsp_tag = '0; in_mem_rsp_data = '0; addr_v = '0; sdata_v = '0; exp_load = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(out_busy), 64'd0);
    chk("reset_req", 64'(out_mem_req), 64'd0);
    chk("reset_done", 64'(out_done), 64'd0);
    chk("reset_addr", 64'(out_mem_addr), 64'd0);
    chk("reset_tag", 64'(out_mem_tag), 64'd0);
    chk_vec("reset_load_data", out_load_data, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Store, two threads, ack in the request cycle.
    addr_v = '0;
    for (int l = 0; l < 64; l++) sdata_v[l*32 +: 32] = $urandom;
    addr_v[31:0]  = 32'h100;
    addr_v[95:64] = 32'h200;
    run_op(64'h5, 1'b1, 1'b0, 0, 0, 0, 1, 1, 1'b0, 1'b0, 0);
    chk("st2_num_req", 64'(ack_tag_log.size()), 64'd2);
    if (ack_tag_log.size() >= 2) begin
      chk("st2_tag0", 64'(ack_tag_log[0]), 64'd0);
      chk("st2_addr0", 64'(ack_addr_log[0]), 64'h100);
      chk("st2_cyc0", 64'(ack_cyc_log[0]), 64'(start_cyc + 1));
      chk("st2_tag1", 64'(ack_tag_log[1]), 64'd2);
      chk("st2_addr1", 64'(ack_addr_log[1]), 64'h200);
      chk("st2_cyc1", 64'(ack_cyc_log[1]), 64'(start_cyc + 2));
    end
    chk("st2_done_cyc", 64'(done_cyc), 64'(start_cyc + 3));

    // Load, three threads, response two cycles after each ack.
    for (int l = 0; l < 64; l++) addr_v[l*32 +: 32] = 32'h1000 + 32'(l * 4);
    run_op(64'h8000_0000_0000_0003, 1'b0, 1'b1, 1, 0, 0, 2, 2, 1'b0, 1'b0, 0);
    chk("ld3_lane0", 64'(out_load_data[31:0]), 64'hA0);
    chk("ld3_lane1", 64'(out_load_data[63:32]), 64'hA1);
    chk("ld3_lane63", 64'(out_load_data[2047:2016]), 64'hDF);
    chk("ld3_other_lanes_zero", 64'(|out_load_data[2015:64]), 64'd0);
    chk("ld3_done_count", 64'(done_cnt), 64'd1);
    chk("ld3_done_cyc", 64'(done_cyc), 64'(start_cyc + 10));

    // Empty mask.
    run_op(64'h0, 1'b0, 1'b0, 0, 0, 0, 1, 1, 1'b0, 1'b0, 0);
    chk("empty_num_req", 64'(ack_tag_log.size()), 64'd0);
    chk("empty_done_cyc", 64'(done_cyc), 64'(start_cyc + 1));

    // Ack held off 5 cycles, stray responses, second start while busy.
    run_op(64'h6, 1'b0, 1'b0, 0, 5, 5, 2, 3, 1'b1, 1'b1, 0);
    chk("hold_num_req", 64'(ack_tag_log.size()), 64'd2);
    if (ack_cyc_log.size() >= 1) chk("hold_first_ack_cyc", 64'(ack_cyc_log[0]), 64'(start_cyc + 6));
    chk("hold_done_count", 64'(done_cnt), 64'd1);

    // Reset while waiting for the second load response.
    addr_v[31:0]  = 32'h10;
    addr_v[63:32] = 32'h20;
    run_op(64'h3, 1'b0, 1'b0, 1, 0, 0, 2, 2, 1'b0, 1'b0, 2);

    // Coalescing candidates: identical lane addresses.
    addr_v[31:0]  = 32'h40;
    addr_v[63:32] = 32'h40;
    run_op(64'h3, 1'b0, 1'b0, 0, 0, 0, 1, 3, 1'b0, 1'b0, 0);
    chk("coal_num_req", 64'(ack_tag_log.size()), COAL ? 64'd1 : 64'd2);
    chk("coal_lane0", 64'(out_load_data[31:0]), 64'hDEAE_F428);
    chk("coal_lane1", 64'(out_load_data[63:32]), 64'hDEAE_F428);

    // Randomized operations.
    for (int r = 0; r < 40; r++) begin
      for (int l = 0; l < 64; l++) begin
        if ($urandom_range(0, 2) == 0) addr_v[l*32 +: 32] = ($urandom_range(0, 1) == 1) ? 32'h40 : 32'h80;
        else addr_v[l*32 +: 32] = $urandom;
        sdata_v[l*32 +: 32] = $urandom;
      end
      case ($urandom_range(0, 3))
        0: exec_r = {$urandom, $urandom};
        1: exec_r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        2: exec_r = 64'd1 << $urandom_range(0, 63);
        default: exec_r = ($urandom_range(0, 3) == 0) ? 64'd0 : {32'd0, $urandom} & {32'd0, $urandom};
      endcase
      run_op(exec_r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, $urandom_range(0, 3),
             1, $urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_addr_sequencer.md
# lsu_addr_sequencer

Consumes the 64-lane address vector produced by the LSU address calculation stage and turns it into a serial stream of single-thread memory requests. It walks the exec mask lowest thread first, issues one request per active thread to global memory or LDS, gathers load responses back into a 64-lane data vector, and signals completion. Sits between LSU address calculation and the memory/LDS request port.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_start  in  1  launches an operation; accepted only while out_busy=0.
- in_ld_st_addr  in  2048  per-thread addresses; lane i = bits [32i+31:32i].
- in_store_data  in  2048  per-thread store data, same lane layout.
- in_exec  in  64  active-thread mask.
- in_is_store  in  1  1 = store, 0 = load.
- in_gm_or_lds  in  1  0 = global memory, 1 = LDS; forwarded unchanged.
- in_mem_ack  in  1  memory accepted the current request.
- in_mem_rsp_valid  in  1  load response valid.
- in_mem_rsp_tag  in  6  thread id of the response.
- in_mem_rsp_data  in  32  load data.
- out_busy  out  1  operation in progress (state != IDLE).
- out_mem_req  out  1  request valid.
- out_mem_wr_en  out  1  request is a store.
- out_mem_addr  out  32  request address.
- out_mem_wr_data  out  32  store data.
- out_mem_tag  out  6  thread id of the request.
- out_gm_or_lds  out  1  target of the request.
- out_load_data  out  2048  gathered load data, same lane layout.
- out_done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, ISSUE, WAIT_RSP, DONE.
- IDLE, in_start=1:
  - capture addr, store data, exec, is_store and gm_or_lds into registers;
  - clear out_load_data to 0;
  - go to ISSUE, or to DONE if in_exec==0.
- Capture is ignored when in_start=1 while busy.
- ISSUE:
  - pick the lowest set bit t of the remaining mask;
  - out_mem_req=1, addr = lane t, tag = t, wr_data = lane t store data, wr_en = is_store.
  - On in_mem_ack:
    - store: clear bit t; go to DONE if the mask is now empty, else stay in ISSUE with the next thread.
    - load: go to WAIT_RSP.
- WAIT_RSP:
  - out_mem_req=0.
  - On in_mem_rsp_valid with tag == t: write data into lane t, clear bit t, then go to ISSUE or DONE.
  - A response with a mismatched tag is dropped.
- DONE: out_done=1 for one cycle, then IDLE.
- Responses arriving in IDLE or ISSUE are ignored.
- Lanes of inactive threads read 0.

## Timing
- Reset values: state IDLE; all outputs 0, including out_load_data; internal mask 0.
- Request is registered. With start at cycle N, out_mem_req is first high at N+1.
- Request hold rule: the request stays stable until the ack cycle. Ack at cycle A gives the next store request at A+1 (one request per cycle at best).
- Load: response at cycle R gives the next request, or DONE, at R+1.
- Empty mask: start at N gives out_done at N+1.
- A response in the same cycle as the ack is ignored; the response must arrive after WAIT_RSP is entered.
- rst_n low mid-operation: abort on the next edge. The request is dropped, no out_done is raised, outputs return to reset values.

## Configuration
- LSU_SEQ_COALESCE_EN defined:
  - applies to loads only;
  - if the next active thread's address equals the last completed load address, its lane is filled with the last response data;
  - no request is issued and the thread costs one ISSUE cycle with out_mem_req=0.
- LSU_SEQ_COALESCE_EN undefined: every active thread issues its own request.
- Store behaviour is identical in both builds.

## Test plan
- **Store, two threads.** exec=0x5, store, addr lanes 0/2 = 0x100/0x200, ack the same cycle as each request.
  - Requests: tag 0 addr 0x100, then tag 2 addr 0x200, in consecutive cycles.
  - out_done 1 cycle after the second ack.
- **Load, three threads.** exec=0x8000_0000_0000_0003, load, response data = 0xA0+tag, 2-cycle response delay.
  - Lanes 0, 1, 63 = 0xA0, 0xA1, 0xDF; all other lanes 0.
  - out_done pulse exactly once.
- **Empty mask.** exec=0 → no out_mem_req; out_done at start+1.
- **Ack hold and stray responses.** Hold in_mem_ack low 5 cycles.
  - addr/tag/wr_data stable throughout.
  - A mismatched-tag response during WAIT_RSP is ignored; a second in_start while busy is ignored.
- **Reset mid-operation.** rst_n low during WAIT_RSP.
  - Next cycle: out_busy=0, out_mem_req=0, out_load_data=0; no out_done.
- **Coalescing.** exec=0x3, both lane addresses 0x40, load.
  - With LSU_SEQ_COALESCE_EN: one request, lanes 0 and 1 both get the response data.
  - Without it: two requests.
